// File: rtl/pcie_us_cq_reg_if.sv
// ---------------------------------------------------------------------------
// pcie_us_cq_reg_if
//   Completer-side bridge between the UltraScale PCIe CQ/CC ports and a simple
//   32-bit register bus. Single-dword memory reads/writes become one register
//   transaction; reads get a CC completion. Memory reads of other lengths and
//   IO requests get an Unsupported Request completion. Anything else is
//   dropped and flagged.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   s_axis_cq_*                completer request stream (from hard IP)
//   m_axis_cc_*                completer completion stream (to hard IP)
//   reg_wr_addr/data/strb/en   register write request, en held until ack
//   reg_wr_ack                 register write acknowledge
//   reg_rd_addr/en             register read request, en held until ack
//   reg_rd_data/ack            register read data, valid with ack
//   completer_id(_enable)      inserted into every CC descriptor
//   status_error_cor           one-cycle pulse: register access timed out
//   status_error_uncor         one-cycle pulse: malformed/unsupported request
// ---------------------------------------------------------------------------
module pcie_us_cq_reg_if #(
   parameter int AXIS_PCIE_DATA_WIDTH    = 256,
   parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH/32,
   parameter int AXIS_PCIE_CQ_USER_WIDTH = (AXIS_PCIE_DATA_WIDTH == 512) ? 183 : 85,
   parameter int AXIS_PCIE_CC_USER_WIDTH = (AXIS_PCIE_DATA_WIDTH == 512) ? 81 : 33,
   parameter int REG_ADDR_WIDTH          = 16,
   parameter int TIMEOUT                 = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,

   input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
   input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
   input  logic                               s_axis_cq_tvalid,
   output logic                               s_axis_cq_tready,
   input  logic                               s_axis_cq_tlast,
   input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,

   output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cc_tdata,
   output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
   output logic                               m_axis_cc_tvalid,
   input  logic                               m_axis_cc_tready,
   output logic                               m_axis_cc_tlast,
   output logic [AXIS_PCIE_CC_USER_WIDTH-1:0] m_axis_cc_tuser,

   output logic [REG_ADDR_WIDTH-1:0]          reg_wr_addr,
   output logic [31:0]                        reg_wr_data,
   output logic [3:0]                         reg_wr_strb,
   output logic                               reg_wr_en,
   input  logic                               reg_wr_ack,
   output logic [REG_ADDR_WIDTH-1:0]          reg_rd_addr,
   output logic                               reg_rd_en,
   input  logic [31:0]                        reg_rd_data,
   input  logic                               reg_rd_ack,

   input  logic [15:0]                        completer_id,
   input  logic                               completer_id_enable,

   output logic                               status_error_cor,
   output logic                               status_error_uncor
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_CPL   = 3'd3;
   localparam logic [2:0] ST_DROP  = 3'd4;

   localparam int            TW      = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [2:0]                state_q, state_d;
   logic                      rdy_q;
   logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [4:0]                lo_addr_q, lo_addr_d;
   logic [3:0]                be_q, be_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [31:0]               rdata_q, rdata_d;
   logic [15:0]               rid_q, rid_d;
   logic [7:0]                tag_q, tag_d;
   logic [2:0]                tc_q, tc_d;
   logic [2:0]                attr_q, attr_d;
   logic                      ur_q, ur_d;
   logic                      cpl_pend_q, cpl_pend_d;
   logic                      drain_q, drain_d;
   logic [TW-1:0]             to_cnt_q, to_cnt_d;
   logic                      err_cor_q, err_cor_d;
   logic                      err_uncor_q, err_uncor_d;

   // ------------------------------------------------------------------------
   // Request decode of the first CQ beat
   // ------------------------------------------------------------------------
   logic        cq_fire;
   logic [3:0]  cq_type;
   logic [10:0] cq_dwc;
   logic        is_wr, is_rd, is_ur;

   assign cq_fire = s_axis_cq_tvalid && s_axis_cq_tready;
   assign cq_type = s_axis_cq_tdata[78:75];
   assign cq_dwc  = s_axis_cq_tdata[74:64];
   assign is_wr   = (cq_type == 4'b0001) && (cq_dwc == 11'd1);
   assign is_rd   = (cq_type == 4'b0000) && (cq_dwc == 11'd1);
   assign is_ur   = ((cq_type == 4'b0000) && (cq_dwc != 11'd1)) ||
                    (cq_type == 4'b0010) || (cq_type == 4'b0011);

   // Held off during reset and for the first cycle after, so the hard IP
   // never sees ready while the block is still coming out of reset.
   assign s_axis_cq_tready = rdy_q && ((state_q == ST_IDLE) || (state_q == ST_DROP));

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      lo_addr_d   = lo_addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rid_d       = rid_q;
      tag_d       = tag_q;
      tc_d        = tc_q;
      attr_d      = attr_q;
      ur_d        = ur_q;
      cpl_pend_d  = cpl_pend_q;
      drain_d     = drain_q;
      to_cnt_d    = to_cnt_q;
      err_cor_d   = 1'b0;
      err_uncor_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cq_fire) begin
               addr_d     = {s_axis_cq_tdata[REG_ADDR_WIDTH-1:2], 2'b00};
               lo_addr_d  = s_axis_cq_tdata[6:2];
               be_d       = s_axis_cq_tuser[3:0];
               wdata_d    = s_axis_cq_tdata[159:128];
               rdata_d    = 32'h0;
               rid_d      = s_axis_cq_tdata[95:80];
               tag_d      = s_axis_cq_tdata[103:96];
               tc_d       = s_axis_cq_tdata[123:121];
               attr_d     = s_axis_cq_tdata[126:124];
               ur_d       = 1'b0;
               cpl_pend_d = 1'b0;
               // Remaining beats of an oversized accepted request are
               // discarded after the register access finishes.
               drain_d    = !s_axis_cq_tlast;
               to_cnt_d   = '0;
               if (is_wr) begin
                  state_d = ST_WRITE;
               end else if (is_rd) begin
                  state_d = ST_READ;
               end else if (is_ur) begin
                  ur_d       = 1'b1;
                  cpl_pend_d = 1'b1;
                  state_d    = s_axis_cq_tlast ? ST_CPL : ST_DROP;
               end else begin
                  err_uncor_d = 1'b1;
                  state_d     = s_axis_cq_tlast ? ST_IDLE : ST_DROP;
               end
            end
         end

         ST_WRITE: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (reg_wr_ack) begin
               state_d = drain_q ? ST_DROP : ST_IDLE;
            end else if (to_cnt_q == TO_LAST) begin
               err_cor_d = 1'b1;
               state_d   = drain_q ? ST_DROP : ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end

         ST_READ: begin
            if (reg_rd_ack) begin
               rdata_d    = reg_rd_data;
               cpl_pend_d = 1'b1;
               state_d    = drain_q ? ST_DROP : ST_CPL;
            end else if (to_cnt_q == TO_LAST) begin
               rdata_d    = 32'hFFFF_FFFF;
               cpl_pend_d = 1'b1;
               err_cor_d  = 1'b1;
               state_d    = drain_q ? ST_DROP : ST_CPL;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end

         ST_DROP: begin
            if (cq_fire && s_axis_cq_tlast) begin
               drain_d = 1'b0;
               state_d = cpl_pend_q ? ST_CPL : ST_IDLE;
            end
         end

         ST_CPL: begin
            if (m_axis_cc_tready) begin
               cpl_pend_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rdy_q       <= 1'b0;
         addr_q      <= '0;
         lo_addr_q   <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rid_q       <= '0;
         tag_q       <= '0;
         tc_q        <= '0;
         attr_q      <= '0;
         ur_q        <= 1'b0;
         cpl_pend_q  <= 1'b0;
         drain_q     <= 1'b0;
         to_cnt_q    <= '0;
         err_cor_q   <= 1'b0;
         err_uncor_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= 1'b1;
         addr_q      <= addr_d;
         lo_addr_q   <= lo_addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rid_q       <= rid_d;
         tag_q       <= tag_d;
         tc_q        <= tc_d;
         attr_q      <= attr_d;
         ur_q        <= ur_d;
         cpl_pend_q  <= cpl_pend_d;
         drain_q     <= drain_d;
         to_cnt_q    <= to_cnt_d;
         err_cor_q   <= err_cor_d;
         err_uncor_q <= err_uncor_d;
      end
   end

   // ------------------------------------------------------------------------
   // Register bus
   // ------------------------------------------------------------------------
   assign reg_wr_en   = (state_q == ST_WRITE);
   assign reg_rd_en   = (state_q == ST_READ);
   assign reg_wr_addr = addr_q;
   assign reg_rd_addr = addr_q;
   assign reg_wr_data = wdata_q;
   assign reg_wr_strb = be_q;

   assign status_error_cor   = err_cor_q;
   assign status_error_uncor = err_uncor_q;

   // ------------------------------------------------------------------------
   // CC completion
   // ------------------------------------------------------------------------
   // Offset of the first enabled byte; an all-zero first_be reads as offset 0.
   function automatic logic [1:0] be_offset(input logic [3:0] be);
      casez (be)
         4'b???1: be_offset = 2'd0;
         4'b??10: be_offset = 2'd1;
         4'b?100: be_offset = 2'd2;
         4'b1000: be_offset = 2'd3;
         default: be_offset = 2'd0;
      endcase
   endfunction

   // Span from first to last enabled byte; a zero-length read reports 1.
   function automatic logic [12:0] be_count(input logic [3:0] be);
      casez (be)
         4'b1??1:                     be_count = 13'd4;
         4'b01?1, 4'b1?10:            be_count = 13'd3;
         4'b0011, 4'b0110, 4'b1100:   be_count = 13'd2;
         default:                     be_count = 13'd1;
      endcase
   endfunction

   logic [127:0] cc_desc;
   logic         in_cpl;

   assign in_cpl = (state_q == ST_CPL);

   always_comb begin
      cc_desc = '0;
      if (in_cpl) begin
         cc_desc[6:0]   = {lo_addr_q, be_offset(be_q)};
         cc_desc[28:16] = be_count(be_q);
         cc_desc[42:32] = ur_q ? 11'd0 : 11'd1;
         cc_desc[45:43] = ur_q ? 3'b001 : 3'b000;
         cc_desc[63:48] = rid_q;
         cc_desc[71:64] = tag_q;
         cc_desc[87:72] = completer_id;
         cc_desc[88]    = completer_id_enable;
         cc_desc[91:89] = tc_q;
         cc_desc[94:92] = attr_q;
         cc_desc[127:96] = ur_q ? 32'h0 : rdata_q;
      end
   end

   always_comb begin
      m_axis_cc_tdata        = '0;
      m_axis_cc_tdata[127:0] = cc_desc;
      m_axis_cc_tkeep        = '0;
      if (in_cpl) begin
         // UR carries only the 3-dword header; data completions add one dword.
         m_axis_cc_tkeep[3:0] = ur_q ? 4'b0111 : 4'b1111;
      end
   end

   assign m_axis_cc_tvalid = in_cpl;
   assign m_axis_cc_tlast  = in_cpl;
   assign m_axis_cc_tuser  = '0;

   // Most CQ descriptor/tuser bits carry nothing this bridge needs.
   logic unused_ok;
   assign unused_ok = ^{s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tuser};

endmodule
